// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen
//   Multi-channel programmable pulse-burst generator. On a start request a
//   channel latches its burst length and low/high phase lengths, emits
//   burst_len pulses (each one low phase followed by one high phase), then
//   raises a one-cycle done strobe. Channels are fully independent.
//
// Parameters
//   NCH     number of independent channels
//   CNT_W   width of burst_len / pulse count fields
//   HALF_W  width of half_lo / half_hi phase-length fields
//
// Ports
//   clk        single rising-edge clock
//   rst        synchronous active-high reset
//   start      [NCH]         per-channel start request (sampled while idle)
//   abort      [NCH]         per-channel abort, returns channel to idle
//   burst_len  [NCH*CNT_W]   pulses per burst, ch k at [k*CNT_W +: CNT_W]
//   half_lo    [NCH*HALF_W]  low-phase length in cycles (0 treated as 1)
//   half_hi    [NCH*HALF_W]  high-phase length in cycles (0 treated as 1)
//   pulse_out  [NCH]         generated pulse train
//   busy       [NCH]         channel running a burst
//   done       [NCH]         one-cycle completion strobe
//   pulse_cnt  [NCH*CNT_W]   pulses emitted in the current/last burst
//
// Configuration
//   PULSE_BURST_CNT_EN  when defined, the pulse_cnt port and its per-channel
//                       counter are present; otherwise both are absent.

module pulse_burst_gen #(
  parameter int NCH    = 1,
  parameter int CNT_W  = 8,
  parameter int HALF_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        start,
  input  logic [NCH-1:0]        abort,
  input  logic [NCH*CNT_W-1:0]  burst_len,
  input  logic [NCH*HALF_W-1:0] half_lo,
  input  logic [NCH*HALF_W-1:0] half_hi,
  output logic [NCH-1:0]        pulse_out,
  output logic [NCH-1:0]        busy,
  output logic [NCH-1:0]        done
`ifdef PULSE_BURST_CNT_EN
  ,
  output logic [NCH*CNT_W-1:0]  pulse_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  // The phase counter counts down to zero, so a phase of length n loads n-1.
  // A programmed length of 0 behaves like 1, which also loads 0.
  function automatic logic [HALF_W-1:0] phase_load(input logic [HALF_W-1:0] len);
    return (len == '0) ? '0 : len - HALF_W'(1);
  endfunction

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t             state_reg, state_next;
    logic [HALF_W-1:0]  phase_reg, phase_next;
    logic [HALF_W-1:0]  lo_reg, lo_next;
    logic [HALF_W-1:0]  hi_reg, hi_next;
    logic [CNT_W-1:0]   remain_reg, remain_next;
    logic               done_reg, done_next;
    logic [CNT_W-1:0]   len_in;
    logic [HALF_W-1:0]  lo_in;
    logic [HALF_W-1:0]  hi_in;
`ifdef PULSE_BURST_CNT_EN
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
`endif

    assign len_in = burst_len[gi*CNT_W +: CNT_W];
    assign lo_in  = half_lo[gi*HALF_W +: HALF_W];
    assign hi_in  = half_hi[gi*HALF_W +: HALF_W];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg  <= IDLE;
        phase_reg  <= '0;
        lo_reg     <= '0;
        hi_reg     <= '0;
        remain_reg <= '0;
        done_reg   <= 1'b0;
`ifdef PULSE_BURST_CNT_EN
        cnt_reg    <= '0;
`endif
      end else begin
        state_reg  <= state_next;
        phase_reg  <= phase_next;
        lo_reg     <= lo_next;
        hi_reg     <= hi_next;
        remain_reg <= remain_next;
        done_reg   <= done_next;
`ifdef PULSE_BURST_CNT_EN
        cnt_reg    <= cnt_next;
`endif
      end
    end

    always_comb begin
      state_next  = state_reg;
      phase_next  = phase_reg;
      lo_next     = lo_reg;
      hi_next     = hi_reg;
      remain_next = remain_reg;
      done_next   = 1'b0;
`ifdef PULSE_BURST_CNT_EN
      cnt_next    = cnt_reg;
`endif
      if (abort[gi]) begin
        // Abort beats everything, including a same-cycle start; the pulse
        // count is left holding its value.
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start[gi]) begin
              lo_next = lo_in;
              hi_next = hi_in;
`ifdef PULSE_BURST_CNT_EN
              cnt_next = '0;
`endif
              if (len_in != '0) begin
                state_next  = LO;
                remain_next = len_in;
                phase_next  = phase_load(lo_in);
              end else begin
                // Empty burst completes immediately without pulsing.
                done_next = 1'b1;
              end
            end
          end
          LO: begin
            if (phase_reg == '0) begin
              state_next = HI;
              phase_next = phase_load(hi_reg);
`ifdef PULSE_BURST_CNT_EN
              cnt_next = cnt_reg + CNT_W'(1);
`endif
            end else begin
              phase_next = phase_reg - HALF_W'(1);
            end
          end
          HI: begin
            if (phase_reg == '0) begin
              if (remain_reg == CNT_W'(1)) begin
                state_next = IDLE;
                done_next  = 1'b1;
              end else begin
                state_next  = LO;
                remain_next = remain_reg - CNT_W'(1);
                phase_next  = phase_load(lo_reg);
              end
            end else begin
              phase_next = phase_reg - HALF_W'(1);
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end

    assign pulse_out[gi] = (state_reg == HI);
    assign busy[gi]      = (state_reg != IDLE);
    assign done[gi]      = done_reg;
`ifdef PULSE_BURST_CNT_EN
    assign pulse_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`endif
  end

endmodule
